// File: rtl/pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : pulse_gen
// Description : Programmable pulse generator (continuous / one-shot / burst)
//               with start/stop control, done strobe and saturating count.
//               Optional start delay enabled by macro PULSE_GEN_PHASE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module pulse_gen #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  high_len,
  input  logic [WIDTH-1:0]  low_len,
`ifdef PULSE_GEN_PHASE_EN
  input  logic [WIDTH-1:0]  phase_len,
`endif
  input  logic [CWIDTH-1:0] burst_len,
  output logic              signal,
  output logic              busy,
  output logic              done,
  output logic [CWIDTH-1:0] count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_DELAY = 2'd3
  } state_t;

  localparam logic [1:0]        c_mode_burst = 2'b10;
  localparam logic [WIDTH-1:0]  c_len_one    = WIDTH'(1);
  localparam logic [CWIDTH-1:0] c_count_one  = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] c_count_max  = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_phase_cnt;
  logic [WIDTH-1:0]  w_phase_cnt_nxt;
  logic [CWIDTH-1:0] r_count;
  logic [CWIDTH-1:0] w_count_nxt;
  logic [CWIDTH-1:0] w_count_inc;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_signal;
  logic              r_busy;
  logic              w_load;

  logic [1:0]        r_mode;
  logic [WIDTH-1:0]  r_high_len;
  logic [WIDTH-1:0]  r_low_len;
  logic [CWIDTH-1:0] r_burst_len;
`ifdef PULSE_GEN_PHASE_EN
  logic [WIDTH-1:0]  r_phase_len;
`endif

  logic [WIDTH-1:0]  w_high_eff;
  logic [WIDTH-1:0]  w_low_eff;
  logic              w_oneshot;
  logic              w_burst;

  // Zero-length phases behave as one cycle; counters run 1..len so the
  // all-ones length never needs a wrap.
  assign w_high_eff  = (r_high_len == '0) ? c_len_one : r_high_len;
  assign w_low_eff   = (r_low_len  == '0) ? c_len_one : r_low_len;
  assign w_oneshot   = r_mode[0];
  assign w_burst     = (r_mode == c_mode_burst);
  assign w_count_inc = (r_count == c_count_max) ? r_count : r_count + c_count_one;

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_cnt_nxt = r_phase_cnt;
    w_count_nxt     = r_count;
    w_done_nxt      = 1'b0;
    w_load          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          if ((mode == c_mode_burst) && (burst_len == '0)) begin
            w_done_nxt  = 1'b1;
            w_count_nxt = '0;
          end
`ifdef PULSE_GEN_PHASE_EN
          else if (phase_len != '0) begin
            w_state_nxt     = ST_DELAY;
            w_phase_cnt_nxt = c_len_one;
            w_count_nxt     = '0;
          end
`endif
          else begin
            w_state_nxt     = ST_HIGH;
            w_phase_cnt_nxt = c_len_one;
            w_count_nxt     = c_count_one;
          end
        end
      end
      ST_HIGH: begin
        if (r_phase_cnt >= w_high_eff) begin
          if (w_oneshot) begin
            w_state_nxt     = ST_IDLE;
            w_phase_cnt_nxt = '0;
            w_done_nxt      = 1'b1;
          end else begin
            w_state_nxt     = ST_LOW;
            w_phase_cnt_nxt = c_len_one;
          end
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + c_len_one;
        end
      end
      ST_LOW: begin
        if (r_phase_cnt >= w_low_eff) begin
          // count never exceeds burst_len in burst mode, so it doubles as
          // the emitted-pulse tally.
          if (w_burst && (r_count >= r_burst_len)) begin
            w_state_nxt     = ST_IDLE;
            w_phase_cnt_nxt = '0;
            w_done_nxt      = 1'b1;
          end else begin
            w_state_nxt     = ST_HIGH;
            w_phase_cnt_nxt = c_len_one;
            w_count_nxt     = w_count_inc;
          end
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + c_len_one;
        end
      end
`ifdef PULSE_GEN_PHASE_EN
      ST_DELAY: begin
        if (r_phase_cnt >= r_phase_len) begin
          w_state_nxt     = ST_HIGH;
          w_phase_cnt_nxt = c_len_one;
          w_count_nxt     = w_count_inc;
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + c_len_one;
        end
      end
`endif
      default: begin
        w_state_nxt     = ST_IDLE;
        w_phase_cnt_nxt = '0;
      end
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (stop) begin
      w_state_nxt     = ST_IDLE;
      w_phase_cnt_nxt = '0;
      w_count_nxt     = r_count;
      w_done_nxt      = 1'b0;
      w_load          = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_phase_cnt <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_signal    <= 1'b0;
      r_busy      <= 1'b0;
      r_mode      <= '0;
      r_high_len  <= '0;
      r_low_len   <= '0;
      r_burst_len <= '0;
`ifdef PULSE_GEN_PHASE_EN
      r_phase_len <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_phase_cnt <= w_phase_cnt_nxt;
      r_count     <= w_count_nxt;
      r_done      <= w_done_nxt;
      r_signal    <= (w_state_nxt == ST_HIGH);
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_load) begin
        r_mode      <= mode;
        r_high_len  <= high_len;
        r_low_len   <= low_len;
        r_burst_len <= burst_len;
`ifdef PULSE_GEN_PHASE_EN
        r_phase_len <= phase_len;
`endif
      end
    end
  end

  assign signal = r_signal;
  assign busy   = r_busy;
  assign done   = r_done;
  assign count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_gen
// Description : Self-checking bench for pulse_gen; expected output vectors
//               {signal,busy,done,count} are queued and popped per cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pulse_gen;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [3:0] burst_len;
  logic [1:0] burst_len2;
`ifdef PULSE_GEN_PHASE_EN
  logic [7:0] phase_len;
`endif
  logic       signal, busy, done;
  logic [3:0] count;
  logic       signal2, busy2, done2;
  logic [1:0] count2;

  logic [6:0] sb[$];
  logic [6:0] exp_v;
  logic [6:0] obs_v;
  int         tests_run;
  int         fails;

  assign burst_len2 = burst_len[1:0];

  pulse_gen #(.WIDTH(8), .CWIDTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .high_len(high_len), .low_len(low_len),
`ifdef PULSE_GEN_PHASE_EN
    .phase_len(phase_len),
`endif
    .burst_len(burst_len),
    .signal(signal), .busy(busy), .done(done), .count(count)
  );

  pulse_gen #(.WIDTH(8), .CWIDTH(2)) dut2 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .high_len(high_len), .low_len(low_len),
`ifdef PULSE_GEN_PHASE_EN
    .phase_len(phase_len),
`endif
    .burst_len(burst_len2),
    .signal(signal2), .busy(busy2), .done(done2), .count(count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Continuous waveform j cycles after the accepting edge.
  function automatic logic [6:0] f_cont(int j, int h, int l, int cmax);
    int c;
    c = j / (h + l) + 1;
    if (c > cmax) c = cmax;
    return {((j % (h + l)) < h), 1'b1, 1'b0, 4'(c)};
  endfunction

  function automatic logic [6:0] f_burst(int j, int h, int l, int n);
    if (j < n * (h + l)) return f_cont(j, h, l, 15);
    return {1'b0, 1'b0, (j == n * (h + l)), 4'(n)};
  endfunction

  function automatic logic [6:0] f_oneshot(int j, int h);
    if (j < h) return {3'b110, 4'd1};
    return {1'b0, 1'b0, (j == h), 4'd1};
  endfunction

  task automatic test_reset();
    start = 1'b1;
    #1;
    sb.push_back(7'd0);
    sb.push_back(7'd0);
    sb.push_back(7'd0);
    exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL reset_dut got %b expected %b", obs_v, exp_v); end
    exp_v = sb.pop_front(); obs_v = {signal2, busy2, done2, 2'b00, count2}; tests_run++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL reset_dut2 got %b expected %b", obs_v, exp_v); end
    repeat (2) @(posedge clock);
    #1; start = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL reset_release got %b expected %b", obs_v, exp_v); end
  endtask

  task automatic test_continuous();
    mode = 2'b00; high_len = 8'd3; low_len = 8'd2;
    for (int j = 0; j < 12; j++) sb.push_back(f_cont(j, 3, 2, 15));
    sb.push_back({3'b000, 4'd3});
    sb.push_back({3'b000, 4'd3});
    for (int j = 0; j < 14; j++) begin
      start = (j == 0); stop = (j == 12);
      @(posedge clock); #1;
      exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL continuous[%0d] got %b expected %b", j, obs_v, exp_v); end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_oneshot();
    mode = 2'b01; high_len = 8'd0; low_len = 8'd5;
    for (int j = 0; j < 4; j++) sb.push_back(f_oneshot(j, 1));
    for (int j = 0; j < 4; j++) begin
      start = (j == 0);
      @(posedge clock); #1;
      exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL oneshot[%0d] got %b expected %b", j, obs_v, exp_v); end
    end
    start = 1'b0;
  endtask

  task automatic test_burst();
    mode = 2'b10; burst_len = 4'd3; high_len = 8'd2; low_len = 8'd1;
    for (int j = 0; j < 11; j++) sb.push_back(f_burst(j, 2, 1, 3));
    for (int j = 0; j < 11; j++) begin
      start = (j == 0);
      @(posedge clock); #1;
      exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL burst[%0d] got %b expected %b", j, obs_v, exp_v); end
    end
    start = 1'b0;
  endtask

  task automatic test_burst_zero();
    mode = 2'b10; burst_len = 4'd0;
    sb.push_back({3'b001, 4'd0});
    sb.push_back({3'b000, 4'd0});
    for (int j = 0; j < 2; j++) begin
      start = (j == 0);
      @(posedge clock); #1;
      exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL burst_zero[%0d] got %b expected %b", j, obs_v, exp_v); end
    end
    start = 1'b0;
  endtask

  task automatic test_start_held();
    mode = 2'b00; high_len = 8'd3; low_len = 8'd2;
    for (int j = 0; j < 15; j++) sb.push_back(f_cont(j, 3, 2, 15));
    sb.push_back({3'b000, 4'd3});
    for (int j = 0; j < 16; j++) begin
      start = (j < 15); stop = (j == 15);
      if (j == 4) high_len = 8'd7;
      @(posedge clock); #1;
      exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL start_held[%0d] got %b expected %b", j, obs_v, exp_v); end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_start_stop();
    // count keeps the 3 left by the aborted run above
    mode = 2'b00; high_len = 8'd3;
    sb.push_back({3'b000, 4'd3});
    sb.push_back({3'b000, 4'd3});
    for (int j = 0; j < 2; j++) begin
      start = (j == 0); stop = (j == 0);
      @(posedge clock); #1;
      exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL start_stop[%0d] got %b expected %b", j, obs_v, exp_v); end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_done_restart();
    mode = 2'b01; high_len = 8'd2;
    for (int j = 0; j < 3; j++) sb.push_back(f_oneshot(j, 2));
    for (int j = 0; j < 4; j++) sb.push_back(f_oneshot(j, 2));
    for (int j = 0; j < 7; j++) begin
      start = (j == 0) || (j == 3);
      @(posedge clock); #1;
      exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL done_restart[%0d] got %b expected %b", j, obs_v, exp_v); end
    end
    start = 1'b0;
  endtask

  task automatic test_saturation();
    mode = 2'b00; high_len = 8'd1; low_len = 8'd1;
    for (int j = 0; j < 12; j++) sb.push_back(f_cont(j, 1, 1, 3));
    sb.push_back({3'b000, 4'd3});
    for (int j = 0; j < 13; j++) begin
      start = (j == 0); stop = (j == 12);
      @(posedge clock); #1;
      exp_v = sb.pop_front(); obs_v = {signal2, busy2, done2, 2'b00, count2}; tests_run++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL saturation[%0d] got %b expected %b", j, obs_v, exp_v); end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = 2'b00; high_len = 8'd3; low_len = 8'd2;
    sb.push_back(f_cont(0, 3, 2, 15));
    sb.push_back(f_cont(1, 3, 2, 15));
    for (int j = 0; j < 2; j++) begin
      start = (j == 0);
      @(posedge clock); #1;
      exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL async_pre[%0d] got %b expected %b", j, obs_v, exp_v); end
    end
    start = 1'b0;
    sb.push_back(7'd0);
    sb.push_back(7'd0);
    sb.push_back(7'd0);
    #2 reset = 1'b0;
    #1;
    exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL async_reset_dut got %b expected %b", obs_v, exp_v); end
    exp_v = sb.pop_front(); obs_v = {signal2, busy2, done2, 2'b00, count2}; tests_run++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL async_reset_dut2 got %b expected %b", obs_v, exp_v); end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL async_release got %b expected %b", obs_v, exp_v); end
  endtask

`ifdef PULSE_GEN_PHASE_EN
  task automatic test_phase();
    mode = 2'b01; phase_len = 8'd4; high_len = 8'd2;
    for (int j = 0; j < 4; j++) sb.push_back({3'b010, 4'd0});
    for (int j = 0; j < 3; j++) sb.push_back(f_oneshot(j, 2));
    for (int j = 0; j < 7; j++) begin
      start = (j == 0);
      @(posedge clock); #1;
      exp_v = sb.pop_front(); obs_v = {signal, busy, done, count}; tests_run++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL phase[%0d] got %b expected %b", j, obs_v, exp_v); end
    end
    start = 1'b0; phase_len = 8'd0;
  endtask
`endif

  initial begin
    tests_run = 0; fails = 0;
    reset = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
    high_len = 8'd0; low_len = 8'd0; burst_len = 4'd0;
`ifdef PULSE_GEN_PHASE_EN
    phase_len = 8'd0;
`endif
    test_reset();
    test_continuous();
    test_oneshot();
    test_burst();
    test_burst_zero();
    test_start_held();
    test_start_stop();
    test_done_restart();
    test_saturation();
    test_async_reset();
`ifdef PULSE_GEN_PHASE_EN
    test_phase();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Synchronous, programmable pulse/waveform generator; parametrised successor to the fixed-delay toggle pulse used in the clock bench.
- Produces a registered output with programmable high/low lengths in clock cycles, in continuous, one-shot or burst mode, with start/stop control and status.
- Sits beside the shared clock generator in benches and small datapaths as a stimulus/timing source.

Parameters:
- WIDTH, 8, bit width of the phase-length counters (high_len, low_len).
- CWIDTH, 4, bit width of the burst length and pulse counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to start a sequence; accepted only in IDLE.
- stop  in  1  abort; forces IDLE from any state.
- mode  in  2  00 continuous, 01 one-shot, 10 burst, 11 reserved (treated as one-shot).
- high_len  in  WIDTH  high-phase length in cycles; 0 treated as 1.
- low_len  in  WIDTH  low-phase length in cycles; 0 treated as 1.
- burst_len  in  CWIDTH  number of pulses in burst mode.
- signal  out  1  generated waveform, registered.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle pulse when a one-shot or burst completes normally.
- count  out  CWIDTH  pulses started since last accepted start; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; signal=0, busy=0, done=0, count=0; internal counters 0.
- States: IDLE, HIGH, LOW (plus DELAY with the optional feature).
- mode, high_len, low_len and burst_len are sampled on the accepting edge. Later changes have no effect until the next start.
- IDLE: start=1 and stop=0 at edge k: count cleared to 0 then incremented to 1; state HIGH; signal=1 from edge k onward (visible in cycle k+1).
  - Exception: burst with burst_len=0 stays IDLE, pulses done for one cycle, and leaves count=0.
- HIGH lasts max(high_len,1) cycles.
  - Exit in one-shot/reserved: go to IDLE, signal=0, done=1 for one cycle.
  - Otherwise: go to LOW, signal=0.
- LOW lasts max(low_len,1) cycles.
  - Exit in continuous: go to HIGH, count+1.
  - Exit in burst: if pulses emitted < burst_len, go to HIGH, count+1; else go to IDLE, done=1.
- Continuous period is exactly H+L cycles with no gap cycles. The burst total busy time is burst_len*(H+L).
- stop=1 in any state: next edge goes to IDLE, signal=0, busy=0, no done pulse; count holds its value.
- start and stop in the same cycle: stop wins, start is ignored.
- start while busy: ignored; does not restart or extend.
- start in the same cycle that done is asserted (state just reached IDLE): accepted normally; done and the new HIGH may coincide.
- count saturates at 2^CWIDTH-1 and does not wrap.
- Counters compare against the sampled lengths; no wrap-around for maximum high_len/low_len = 2^WIDTH-1.
- Reset mid-sequence: immediate return to reset values; no done.

Optional Feature:
- Macro PULSE_GEN_PHASE_EN.
- Defined:
  - Adds input phase_len (WIDTH), sampled at start.
  - Adds DELAY state entered on the accepting start; signal stays 0 for phase_len cycles, then HIGH.
  - phase_len=0 skips DELAY, identical to the non-featured timing.
  - busy=1 during DELAY; stop aborts DELAY.
  - count increments on entering HIGH, not on entering DELAY.
- Undefined: no phase_len port and no DELAY state; HIGH is entered directly on start.

Test Plan:
- Reset then continuous, high_len=3, low_len=2, start one cycle: signal 1,1,1,0,0 repeating with period 5; count 1,2,3... ; busy=1; stop at cycle 12 -> signal=0, busy=0 next cycle, no done.
- One-shot high_len=0, low_len=5: single 1-cycle high pulse, then IDLE; done=1 exactly on the cycle signal falls; count=1.
- Burst burst_len=3, high_len=2, low_len=1: three pulses, busy high for 9 cycles, done once, count=3; burst_len=0 -> done next cycle, signal never high.
- start held high continuously in continuous mode, with high_len changed mid-run from 3 to 7: no restart, period stays 5. start+stop same cycle in IDLE: nothing happens.
- CWIDTH=2, continuous, run 6 periods: count saturates at 3. Assert reset low asynchronously mid-HIGH: signal=0 and count=0 without waiting for a clock edge.
- With PULSE_GEN_PHASE_EN, phase_len=4, high_len=2, one-shot: signal low 4 cycles after start, busy=1 throughout, then high 2 cycles, done, count=1.
